// File: rtl/ocimem_access_sequencer_if.sv
// Avalon-MM view of the CPU debug_mem_slave port into the OCI memory sequencer.
// The CPU side is the master; the sequencer is the slave.
interface ocimem_access_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_waitrequest;
    logic [31:0]       cpu_readdata;

    modport master (
        output cpu_read, cpu_write, cpu_address,
        output cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address,
        input  cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata
    );
endinterface

// File: rtl/ocimem_access_sequencer.sv
// OCI monitor RAM sequencer: arbitrates JTAG debug-slave ops and CPU Avalon access.
// Define OCIMEM_ROM_PROTECT_EN to block CPU writes to the top address quarter.
module ocimem_access_sequencer #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [37:0]               jdo,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    input  logic                      take_no_action_ocimem_a,
    ocimem_access_sequencer_if.slave  cpu,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [31:0]               ram_wdata,
    output logic [3:0]                ram_be,
    output logic                      ram_wren,
    input  logic [31:0]               ram_rdata,
    output logic [31:0]               MonDReg,
    output logic [ADDR_W-1:0]         MonAReg,
    output logic                      jtag_busy
);
    typedef enum logic [2:0] {
        IDLE, J_WR, J_RD, J_RDWAIT, C_WR, C_RD, C_RDWAIT
    } state_e;

    state_e            state_q, state_d;
    logic              slot_vld_q, slot_vld_d;
    logic              slot_wr_q, slot_wr_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [31:0]       slot_data_q, slot_data_d;
    logic [ADDR_W-1:0] mona_q, mona_d;
    logic [31:0]       mond_q, mond_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rd_last;
    logic              cpu_wr_ok;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign rd_last    = (cnt_q == 2'(RD_LAT - 1));

`ifdef OCIMEM_ROM_PROTECT_EN
    assign cpu_wr_ok = (cpu.cpu_address[ADDR_W-1 -: 2] != 2'b11);
`else
    assign cpu_wr_ok = 1'b1;
`endif

    // Strobe capture: a new strobe overrides the end-of-op slot clear
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_wr_d   = slot_wr_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        mona_d      = mona_q;
        mond_d      = mond_q;
        if (state_q == J_WR) begin
            slot_vld_d = 1'b0;
        end
        if (state_q == J_RDWAIT && rd_last) begin
            slot_vld_d = 1'b0;
            mond_d     = ram_rdata;
        end
        if (take_action_ocimem_a) begin
            mona_d = jdo[ADDR_W+16:17];
            if (jdo[34]) begin
                slot_vld_d  = 1'b1;
                slot_wr_d   = 1'b0;
                slot_addr_d = jdo[ADDR_W+16:17];
            end
        end else if (take_action_ocimem_b) begin
            slot_vld_d  = 1'b1;
            slot_wr_d   = 1'b1;
            slot_addr_d = mona_q;
            slot_data_d = jdo[34:3];
            mona_d      = mona_q + ADDR_W'(1);
            mond_d      = jdo[34:3];
        end else if (take_no_action_ocimem_a) begin
            slot_vld_d  = 1'b1;
            slot_wr_d   = 1'b0;
            slot_addr_d = mona_q;
            mona_d      = mona_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        rdata_d             = rdata_q;
        ram_addr            = '0;
        ram_wdata           = '0;
        ram_be              = '0;
        ram_wren            = 1'b0;
        cpu.cpu_waitrequest = 1'b1;
        cpu.cpu_readdata    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (slot_vld_d) begin
                    state_d = slot_wr_d ? J_WR : J_RD;
                end else if (cpu.cpu_write) begin
                    state_d = C_WR;
                end else if (cpu.cpu_read) begin
                    state_d = C_RD;
                end
            end
            J_WR: begin
                ram_addr  = slot_addr_q;
                ram_wdata = slot_data_q;
                ram_be    = 4'hF;
                ram_wren  = 1'b1;
                state_d   = IDLE;
            end
            J_RD: begin
                ram_addr = slot_addr_q;
                cnt_d    = '0;
                state_d  = J_RDWAIT;
            end
            J_RDWAIT: begin
                ram_addr = slot_addr_q;
                if (rd_last) state_d = IDLE;
                else         cnt_d   = cnt_q + 2'd1;
            end
            C_WR: begin
                ram_addr            = cpu.cpu_address;
                ram_wdata           = cpu.cpu_writedata;
                ram_be              = cpu.cpu_byteenable;
                ram_wren            = cpu_wr_ok;
                cpu.cpu_waitrequest = 1'b0;
                state_d             = IDLE;
            end
            C_RD: begin
                ram_addr = cpu.cpu_address;
                cnt_d    = '0;
                state_d  = C_RDWAIT;
            end
            C_RDWAIT: begin
                ram_addr = cpu.cpu_address;
                if (rd_last) begin
                    cpu.cpu_waitrequest = 1'b0;
                    cpu.cpu_readdata    = ram_rdata;
                    rdata_d             = ram_rdata;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            slot_vld_q  <= 1'b0;
            slot_wr_q   <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            mona_q      <= '0;
            mond_q      <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_vld_q  <= slot_vld_d;
            slot_wr_q   <= slot_wr_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            mona_q      <= mona_d;
            mond_q      <= mond_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign MonAReg   = mona_q;
    assign MonDReg   = mond_q;
    assign jtag_busy = slot_vld_q || (state_q == J_WR)
                    || (state_q == J_RD) || (state_q == J_RDWAIT);
endmodule

// File: tb/tb_ocimem_access_sequencer.sv
// Self-checking bench for ocimem_access_sequencer with a behavioural 256x32 RAM.
// Read results are queued when stimulus is issued and popped when they appear.
module tb_ocimem_access_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_wren;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    ocimem_access_sequencer_if #(.ADDR_W(8)) bus ();

    ocimem_access_sequencer #(.ADDR_W(8), .RD_LAT(1)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu                     (bus),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_wren                (ram_wren),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy)
    );

    always #5 clk = ~clk;

    // One-cycle read latency RAM, old data on read-during-write
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] d);
        jdo = d;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = n;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    function automatic logic [37:0] jaddr(input logic [7:0] a);
        jaddr = 38'(a) << 17;
    endfunction

    function automatic logic [37:0] jdata(input logic [31:0] d);
        jdata = 38'(d) << 3;
    endfunction

    task automatic wait_jtag_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!jtag_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s jtag_busy stuck got 1 want 0", name);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [31:0] got);
        logic [31:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s got %h want <queue empty>", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s got %h want %h", name, got, want);
            end
        end
    endtask

    task automatic cpu_wr(input string name, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        bit ok = 1'b0;
        bus.cpu_address = a;
        bus.cpu_writedata = d;
        bus.cpu_byteenable = be;
        bus.cpu_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.cpu_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.cpu_write = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s write handshake got timeout want waitrequest 0", name);
        end
    endtask

    task automatic cpu_rd(input string name, input logic [7:0] a);
        bit ok = 1'b0;
        logic [31:0] got;
        bus.cpu_address = a;
        bus.cpu_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.cpu_waitrequest) begin
                ok = 1'b1;
                got = bus.cpu_readdata;
                break;
            end
        end
        tick();
        bus.cpu_read = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s read handshake got timeout want waitrequest 0", name);
        end else begin
            pop_cmp(name, got);
            chk({name, "_wait_one"}, 32'(bus.cpu_waitrequest), 32'd1);
        end
    endtask

    task automatic test_reset();
        #3;
        chk("rst_mond", MonDReg, 32'h0);
        chk("rst_mona", 32'(MonAReg), 32'h0);
        chk("rst_wait", 32'(bus.cpu_waitrequest), 32'd1);
        chk("rst_rdata", bus.cpu_readdata, 32'h0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_be", 32'(ram_be), 32'h0);
        chk("rst_busy", 32'(jtag_busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_jtag_load_write();
        mem[8'h11] = 32'hA5A5_0011;
        strobe(1'b1, 1'b0, 1'b0, jaddr(8'h10));
        chk("load_mona", 32'(MonAReg), 32'h10);
        strobe(1'b0, 1'b1, 1'b0, jdata(32'hDEAD_BEEF));
        chk("wr_mona", 32'(MonAReg), 32'h11);
        chk("wr_mond", MonDReg, 32'hDEAD_BEEF);
        wait_jtag_idle("wr_idle");
        chk("wr_ram", mem[8'h10], 32'hDEAD_BEEF);
        exp_q.push_back(32'hA5A5_0011);
        strobe(1'b0, 1'b0, 1'b1, '0);
        chk("rd_mona", 32'(MonAReg), 32'h12);
        tick();
        tick();
        pop_cmp("rd_mond_lat", MonDReg);
        wait_jtag_idle("rd_idle");
    endtask

    task automatic test_wrap();
        mem[8'hFF] = 32'hCAFE_00FF;
        strobe(1'b1, 1'b0, 1'b0, jaddr(8'hFF));
        chk("wrap_load", 32'(MonAReg), 32'hFF);
        exp_q.push_back(32'hCAFE_00FF);
        strobe(1'b0, 1'b0, 1'b1, '0);
        chk("wrap_mona", 32'(MonAReg), 32'h00);
        tick();
        tick();
        pop_cmp("wrap_mond", MonDReg);
        wait_jtag_idle("wrap_idle");
    endtask

    task automatic test_collision();
        int jw = -1;
        int cw = -1;
        int done = -1;
        logic [31:0] got = '0;
        mem[8'h20] = 32'h2020_2020;
        strobe(1'b1, 1'b0, 1'b0, jaddr(8'h30));
        exp_q.push_back(32'h2020_2020);
        bus.cpu_address = 8'h20;
        bus.cpu_read = 1'b1;
        jdo = jdata(32'h1357_9BDF);
        take_action_ocimem_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            take_action_ocimem_b = 1'b0;
            if (done >= 0) begin
                bus.cpu_read = 1'b0;
                break;
            end
            if (ram_wren && ram_addr == 8'h30 && jw < 0) jw = i;
            if (!bus.cpu_waitrequest) begin
                done = i;
                got = bus.cpu_readdata;
            end
        end
        bus.cpu_read = 1'b0;
        checks++;
        if (!(jw >= 0 && done > jw)) begin
            errors++;
            $display("FAIL col_order got jw=%0d rd=%0d want jtag write before read", jw, done);
        end
        pop_cmp("col_rdata", got);
        chk("col_wait_one", 32'(bus.cpu_waitrequest), 32'd1);
        chk("col_ram", mem[8'h30], 32'h1357_9BDF);
        tick();
        // CPU write already in C_WR when the JTAG strobe lands
        jw = -1;
        bus.cpu_address = 8'h40;
        bus.cpu_writedata = 32'h0BAD_F00D;
        bus.cpu_byteenable = 4'hF;
        bus.cpu_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            take_action_ocimem_b = 1'b0;
            if (i == 1) bus.cpu_write = 1'b0;
            if (ram_wren && ram_addr == 8'h40 && cw < 0) cw = i;
            if (ram_wren && ram_addr == 8'h31 && jw < 0) jw = i;
            if (i == 0) begin
                jdo = jdata(32'h600D_CAFE);
                take_action_ocimem_b = 1'b1;
            end
            if (jw >= 0 && i > 1) break;
        end
        bus.cpu_write = 1'b0;
        checks++;
        if (!(cw >= 0 && jw > cw)) begin
            errors++;
            $display("FAIL col_cpu_first got cw=%0d jw=%0d want cpu write first", cw, jw);
        end
        wait_jtag_idle("col_idle");
        chk("col_cpu_ram", mem[8'h40], 32'h0BAD_F00D);
        chk("col_jtag_ram", mem[8'h31], 32'h600D_CAFE);
    endtask

    task automatic test_byte_enable();
        mem[8'h50] = 32'hFFFF_FFFF;
        cpu_wr("be_wr", 8'h50, 32'h1122_3344, 4'b0101);
        chk("be_ram", mem[8'h50], 32'hFF22_FF44);
        exp_q.push_back(32'hFF22_FF44);
        cpu_rd("be_rd", 8'h50);
    endtask

    task automatic test_rom_protect();
        logic [31:0] want;
`ifdef OCIMEM_ROM_PROTECT_EN
        want = 32'h0;
`else
        want = 32'h5555_AAAA;
`endif
        mem[8'hC0] = 32'h0;
        cpu_wr("rom_cpu_wr", 8'hC0, 32'h5555_AAAA, 4'hF);
        chk("rom_cpu_ram", mem[8'hC0], want);
        strobe(1'b1, 1'b0, 1'b0, jaddr(8'hC0));
        strobe(1'b0, 1'b1, 1'b0, jdata(32'h7777_8888));
        wait_jtag_idle("rom_idle");
        chk("rom_jtag_ram", mem[8'hC0], 32'h7777_8888);
    endtask

    task automatic test_reset_mid_write();
        mem[8'h60] = 32'h0;
        strobe(1'b1, 1'b0, 1'b0, jaddr(8'h60));
        strobe(1'b0, 1'b1, 1'b0, jdata(32'h1234_5678));
        chk("mid_in_jwr", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_wren", 32'(ram_wren), 32'd0);
        chk("mid_addr", 32'(ram_addr), 32'h0);
        chk("mid_mona", 32'(MonAReg), 32'h0);
        chk("mid_mond", MonDReg, 32'h0);
        chk("mid_busy", 32'(jtag_busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("mid_ram", mem[8'h60], 32'h0);
        chk("mid_post_wren", 32'(ram_wren), 32'd0);
        chk("mid_post_wait", 32'(bus.cpu_waitrequest), 32'd1);
        exp_q.push_back(32'hA5A5_0011);
        cpu_rd("mid_post_rd", 8'h11);
    endtask

    initial begin
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_writedata = '0;
        bus.cpu_byteenable = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
        test_reset();
        test_jtag_load_write();
        test_wrap();
        test_collision();
        test_byte_enable();
        test_rom_protect();
        test_reset_mid_write();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
